weight_stationary_array: RTL and testbench

- Parametrised weight-stationary systolic array for fixed-point matrix-vector products in the neural-network datapath.
- Includes its own weight-load sequencing and input skew.
- Includes output deskew with a single aligned valid.
- Applies rounding and saturation back to storage width.
- Accepts one activation vector per cycle after weights are loaded, and emits one COLS-wide result vector per accepted input.

---
 rtl/weight_stationary_array.sv | 231 +++++++++++++++++++++++
 tb/tb_weight_stationary_array.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stationary_array.sv
// Weight-stationary systolic array: sequenced weight load, input skew, MAC grid,
// output deskew, then round-half-up and saturate back to storage width.
module weight_stationary_array #(
  parameter int unsigned ROWS                 = 8,
  parameter int unsigned COLS                 = 8,
  parameter int unsigned FIXED_POINT_WIDTH    = 16,
  parameter int unsigned FIXED_POINT_POSITION = 10,
  parameter int unsigned ACC_WIDTH            = 2 * FIXED_POINT_WIDTH + $clog2(ROWS)
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              weight_valid_in,
  input  logic [COLS*FIXED_POINT_WIDTH-1:0] weights_in,
  output logic                              weight_ready_out,
  input  logic                              act_valid_in,
  input  logic [ROWS*FIXED_POINT_WIDTH-1:0] activations_in,
  output logic                              act_ready_out,
  output logic                              sum_valid_out,
  output logic [COLS*FIXED_POINT_WIDTH-1:0] sum_out,
  output logic [COLS-1:0]                   sat_out
);

  localparam int unsigned W     = FIXED_POINT_WIDTH;
  localparam int unsigned F     = FIXED_POINT_POSITION;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned EXT   = ACC_WIDTH + 1;
  localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned IF_W  = $clog2(ROWS + COLS + 1);
  localparam int unsigned LAT   = ROWS + COLS;

  localparam logic signed [EXT-1:0] RND_BIAS = EXT'(2 ** (F - 1));
  localparam logic signed [EXT-1:0] SAT_MAX  = EXT'(2 ** (W - 1) - 1);
  localparam logic signed [EXT-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [W-1:0]          MAX_W    = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]          MIN_W    = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        row_cnt_q, row_cnt_d;
  logic                    w_we;
  logic [CNT_W-1:0]        w_row;
  logic                    act_acc;
  logic [IF_W-1:0]         inflight_q;

  logic signed [W-1:0]         w_q     [ROWS][COLS];
  logic signed [W-1:0]         act_q   [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] psum_q  [ROWS][COLS];
  logic [ROWS*W-1:0]           skew_in, skew_out;
  logic [COLS*ACC_WIDTH-1:0]   col_raw;
  logic [LAT-1:0]              vpipe_q;
  logic signed [EXT-1:0]       raw_ext, shifted;
  logic [COLS*W-1:0]           rnd_val;
  logic [COLS-1:0]             rnd_sat;

  function automatic logic signed [ACC_WIDTH-1:0] mac_term(input logic signed [W-1:0] a,
                                                           input logic signed [W-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return ACC_WIDTH'(p);
  endfunction

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Next state, handshakes and weight write strobe
  always_comb begin
    state_d          = state_q;
    row_cnt_d        = row_cnt_q;
    weight_ready_out = 1'b0;
    act_ready_out    = 1'b0;
    w_we             = 1'b0;
    w_row            = row_cnt_q;
    case (state_q)
      IDLE: begin
        weight_ready_out = 1'b1;
        if (weight_valid_in) begin
          w_we      = 1'b1;
          w_row     = '0;
          row_cnt_d = CNT_W'(1);
          state_d   = (ROWS == 1) ? READY : LOAD;
        end
      end
      LOAD: begin
        weight_ready_out = 1'b1;
        if (weight_valid_in) begin
          w_we      = 1'b1;
          row_cnt_d = row_cnt_q + CNT_W'(1);
          if (row_cnt_q == CNT_W'(ROWS - 1)) state_d = READY;
        end
      end
      READY: begin
        act_ready_out    = 1'b1;
        // Reloading only with an empty pipe keeps weights stable under live data
        weight_ready_out = (inflight_q == '0) & ~act_valid_in;
        if (weight_valid_in && weight_ready_out) begin
          w_we      = 1'b1;
          w_row     = '0;
          row_cnt_d = CNT_W'(1);
          state_d   = (ROWS == 1) ? READY : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign act_acc = act_valid_in & act_ready_out;

  // Stationary weight storage
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
    end else if (w_we) begin
      for (int r = 0; r < ROWS; r++)
        if (w_row == CNT_W'(r))
          for (int c = 0; c < COLS; c++) w_q[r][c] <= weights_in[c*W +: W];
    end
  end

  // Input skew: row r is held back r cycles; idle cycles inject zeros
  assign skew_in = act_acc ? activations_in : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_pass
      assign skew_out[0 +: W] = skew_in[0 +: W];
    end else begin : g_dly
      logic [W-1:0] dly_q [r];
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int j = 0; j < r; j++) dly_q[j] <= '0;
        end else begin
          dly_q[0] <= skew_in[r*W +: W];
          for (int j = 1; j < r; j++) dly_q[j] <= dly_q[j-1];
        end
      end
      assign skew_out[r*W +: W] = dly_q[r-1];
    end
  end

  // MAC grid: activations flow right, partial sums flow down
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          act_q[r][c]  <= '0;
          psum_q[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        act_q[r][0] <= skew_out[r*W +: W];
        for (int c = 1; c < COLS; c++) act_q[r][c] <= act_q[r][c-1];
      end
      for (int c = 0; c < COLS; c++) begin
        psum_q[0][c] <= mac_term(act_q[0][c], w_q[0][c]);
        for (int r = 1; r < ROWS; r++)
          psum_q[r][c] <= psum_q[r-1][c] + mac_term(act_q[r][c], w_q[r][c]);
      end
    end
  end

  // Output deskew: column c waits COLS-1-c cycles so all columns line up
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int unsigned D = COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign col_raw[c*ACC_WIDTH +: ACC_WIDTH] = psum_q[ROWS-1][c];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] dly_q [D];
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int j = 0; j < int'(D); j++) dly_q[j] <= '0;
        end else begin
          dly_q[0] <= psum_q[ROWS-1][c];
          for (int j = 1; j < int'(D); j++) dly_q[j] <= dly_q[j-1];
        end
      end
      assign col_raw[c*ACC_WIDTH +: ACC_WIDTH] = dly_q[D-1];
    end
  end

  // Round half-up from 2F to F fractional bits, then clamp to W bits
  always_comb begin
    rnd_val = '0;
    rnd_sat = '0;
    raw_ext = '0;
    shifted = '0;
    for (int c = 0; c < COLS; c++) begin
      raw_ext = EXT'(signed'(col_raw[c*ACC_WIDTH +: ACC_WIDTH]));
      shifted = (raw_ext + RND_BIAS) >>> F;
      if (shifted > SAT_MAX) begin
        rnd_val[c*W +: W] = MAX_W;
        rnd_sat[c]        = 1'b1;
      end else if (shifted < SAT_MIN) begin
        rnd_val[c*W +: W] = MIN_W;
        rnd_sat[c]        = 1'b1;
      end else begin
        rnd_val[c*W +: W] = shifted[W-1:0];
      end
    end
  end

  // Valid pipeline, in-flight tracking and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vpipe_q       <= '0;
      inflight_q    <= '0;
      sum_valid_out <= 1'b0;
      sum_out       <= '0;
      sat_out       <= '0;
    end else begin
      vpipe_q       <= {vpipe_q[LAT-2:0], act_acc};
      sum_valid_out <= vpipe_q[LAT-1];
      sum_out       <= rnd_val;
      sat_out       <= rnd_sat;
      case ({act_acc, sum_valid_out})
        2'b10:   inflight_q <= inflight_q + IF_W'(1);
        2'b01:   inflight_q <= inflight_q - IF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stationary_array.sv
// Directed bench: expected result vectors are queued at activation accept and
// checked by an independent monitor against value, saturation and arrival cycle.
module tb_weight_stationary_array;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int W    = 16;
  localparam int LAT  = ROWS + COLS;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              weight_valid_in;
  logic [COLS*W-1:0] weights_in;
  logic              weight_ready_out;
  logic              act_valid_in;
  logic [ROWS*W-1:0] activations_in;
  logic              act_ready_out;
  logic              sum_valid_out;
  logic [COLS*W-1:0] sum_out;
  logic [COLS-1:0]   sat_out;

  weight_stationary_array dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .weight_valid_in  (weight_valid_in),
    .weights_in       (weights_in),
    .weight_ready_out (weight_ready_out),
    .act_valid_in     (act_valid_in),
    .activations_in   (activations_in),
    .act_ready_out    (act_ready_out),
    .sum_valid_out    (sum_valid_out),
    .sum_out          (sum_out),
    .sat_out          (sat_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [COLS*W-1:0] sum;
    logic [COLS-1:0]   sat;
    int                due;
  } exp_t;

  exp_t              sb[$];
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_fail = 0;
  int                last_due = 0;
  logic [COLS*W-1:0] wmat [ROWS];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [COLS*W-1:0] rep(input logic [W-1:0] x);
    logic [COLS*W-1:0] v;
    for (int i = 0; i < COLS; i++) v[i*W +: W] = x;
    return v;
  endfunction

  function automatic logic [COLS*W-1:0] one_at(input int idx, input logic [W-1:0] x);
    logic [COLS*W-1:0] v;
    v = '0;
    v[idx*W +: W] = x;
    return v;
  endfunction

  // Monitor: every presented result must match the oldest expectation, on time
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_result_due", 128'(cyc), 128'(sb[0].due));
        void'(sb.pop_front());
      end
      if (sum_valid_out) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 128'(sum_out), 128'(0));
          if (sum_out == '0) begin
            n_fail++;
            $display("FAIL unexpected_valid: got valid expected none (cycle %0d)", cyc);
          end
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum_out", 128'(sum_out), 128'(e.sum));
          chk("sat_out", 128'(sat_out), 128'(e.sat));
          chk("latency", 128'(cyc), 128'(e.due));
        end
      end
    end
  end

  task automatic idle(input int n);
    act_valid_in    = 1'b0;
    weight_valid_in = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic load_weights(output int first_rdy);
    logic acc;
    int   tries;
    first_rdy    = -1;
    act_valid_in = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      weight_valid_in = 1'b1;
      weights_in      = wmat[r];
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 200) begin
        @(negedge clk_in);
        if (weight_ready_out) begin
          acc = 1'b1;
          if (r == 0) first_rdy = cyc;
        end
        @(posedge clk_in);
        #1;
        tries++;
      end
      if (!acc) chk("weight_beat_timeout", 128'(0), 128'(1));
    end
    weight_valid_in = 1'b0;
    chk("act_ready_after_load", 128'(act_ready_out), 128'(1));
  endtask

  task automatic send_act(input logic [ROWS*W-1:0] v, input logic [COLS*W-1:0] es,
                          input logic [COLS-1:0] esat, output logic wr_seen);
    logic acc;
    int   tries;
    exp_t e;
    act_valid_in   = 1'b1;
    activations_in = v;
    acc     = 1'b0;
    tries   = 0;
    wr_seen = 1'b0;
    while (!acc && tries < 50) begin
      @(negedge clk_in);
      if (act_ready_out) begin
        acc      = 1'b1;
        wr_seen  = weight_ready_out;
        e.sum    = es;
        e.sat    = esat;
        e.due    = cyc + 1 + LAT;
        last_due = e.due;
        sb.push_back(e);
      end
      @(posedge clk_in);
      #1;
      tries++;
    end
    if (!acc) chk("act_accept_timeout", 128'(0), 128'(1));
  endtask

  logic [COLS*W-1:0] vec_id;
  logic              wr;
  int                fr;
  int                t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n_in        = 1'b0;
    weight_valid_in = 1'b0;
    weights_in      = '0;
    act_valid_in    = 1'b0;
    activations_in  = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_sum_valid", 128'(sum_valid_out), 128'(0));
    chk("rst_sum_out", 128'(sum_out), 128'(0));
    chk("rst_sat_out", 128'(sat_out), 128'(0));
    chk("rst_act_ready", 128'(act_ready_out), 128'(0));
    chk("rst_weight_ready", 128'(weight_ready_out), 128'(1));
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Identity weights: result equals the activation vector
    for (int r = 0; r < ROWS; r++) wmat[r] = one_at(r, 16'h0400);
    load_weights(fr);
    vec_id = {16'h2000, 16'h1C00, 16'h1800, 16'h1400, 16'h1000, 16'h0C00, 16'h0800, 16'h0400};
    send_act(vec_id, vec_id, 8'h00, wr);
    send_act(rep(16'hFF00), rep(16'hFF00), 8'h00, wr);
    idle(20);

    // All 1.0 weights, 16 back-to-back vectors of 8 equal elements (i+1)/16
    for (int r = 0; r < ROWS; r++) wmat[r] = rep(16'h0400);
    load_weights(fr);
    for (int i = 0; i < 16; i++)
      send_act(rep(16'((i + 1) * 16'h0040)), rep(16'((i + 1) * 16'h0200)), 8'h00, wr);

    // Reload requested with vectors in flight must wait for the pipe to drain
    for (int r = 0; r < ROWS; r++) wmat[r] = rep(16'h7FFF);
    load_weights(fr);
    chk("reload_waits_inflight", 128'(fr), 128'(last_due + 1));
    send_act(rep(16'h7FFF), rep(16'h7FFF), 8'hFF, wr);
    idle(20);

    // Simultaneous weight and activation: activation wins
    weight_valid_in = 1'b1;
    weights_in      = rep(16'h1111);
    send_act(rep(16'h8001), rep(16'h8000), 8'hFF, wr);
    chk("act_priority_weight_ready", 128'(wr), 128'(0));

    // Rounding boundaries on a single 0x0001 weight
    for (int r = 0; r < ROWS; r++) wmat[r] = '0;
    wmat[0] = one_at(0, 16'h0001);
    load_weights(fr);
    chk("reload_after_priority", 128'(fr), 128'(last_due + 1));
    send_act(one_at(0, 16'h0200), one_at(0, 16'h0001), 8'h00, wr);
    send_act(one_at(0, 16'h01FF), '0, 8'h00, wr);
    send_act(one_at(0, 16'hFE00), '0, 8'h00, wr);
    send_act(one_at(0, 16'hFDFF), one_at(0, 16'hFFFF), 8'h00, wr);
    idle(20);

    // Reset during row 3 of a load
    for (int r = 0; r < ROWS; r++) wmat[r] = rep(16'h0123);
    weight_valid_in = 1'b1;
    weights_in      = wmat[0];
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("mid_load_rst_weight_ready", 128'(weight_ready_out), 128'(1));
    chk("mid_load_rst_act_ready", 128'(act_ready_out), 128'(0));
    weight_valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    for (int r = 0; r < ROWS; r++) wmat[r] = one_at(r, 16'h0400);
    load_weights(fr);

    // Reset while results are streaming out
    for (int i = 0; i < 4; i++) send_act(rep(16'((i + 1) * 16'h0100)), rep(16'((i + 1) * 16'h0100)), 8'h00, wr);
    act_valid_in = 1'b0;
    t = 0;
    do begin
      @(negedge clk_in);
      t++;
    end while (!sum_valid_out && t < 40);
    chk("mid_compute_first_valid", 128'(sum_valid_out), 128'(1));
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mid_compute_rst_valid", 128'(sum_valid_out), 128'(0));
    chk("mid_compute_rst_sum", 128'(sum_out), 128'(0));
    chk("mid_compute_rst_act_ready", 128'(act_ready_out), 128'(0));
    sb.delete();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    load_weights(fr);
    send_act(vec_id, vec_id, 8'h00, wr);
    idle(25);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
